// File: rtl/ifetch_queue.sv
// ifetch_queue: PC-driven instruction fetch with one in-flight BRAM read and a small {inst, pc} queue.
// Optional IFETCH_BYPASS_EN forwards the BRAM word straight to decode when the queue is empty.
// Revision: 1.0
`default_nettype none

module ifetch_queue #(
  parameter int IMEM_AW    = 15,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [26:0]        pc,
  input  logic               redirect,
  output logic               pc_adv,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               id_valid,
  output logic [31:0]        id_inst,
  output logic [26:0]        id_pc,
  input  logic               id_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   inst_q [FIFO_DEPTH];
  logic [26:0]   pc_q   [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          f1_valid;
  logic [26:0]   f1_pc;

  logic [CW:0]   occ;
  logic          bypass;
  logic          deq;
  logic          issue;
  logic          push;
  logic          pop;

  always_comb begin
`ifdef IFETCH_BYPASS_EN
    bypass = (count == '0) && f1_valid;
`else
    bypass = 1'b0;
`endif
    id_valid = (count != '0) || bypass;
    id_inst  = bypass ? imem_rdata : inst_q[rd_ptr];
    id_pc    = bypass ? f1_pc      : pc_q[rd_ptr];
    deq      = id_valid && id_ready;
    // A bypassed word that decode takes never enters the queue.
    push     = f1_valid && !(bypass && id_ready);
    pop      = deq && !bypass;
    // Credit check: queued plus in-flight words must fit, counting a same-cycle pop.
    occ      = {1'b0, count} + {{CW{1'b0}}, f1_valid};
    issue    = !rst && !redirect && ((occ < DEPTH_C) || ((occ == DEPTH_C) && deq));
    imem_en  = issue;
    pc_adv   = issue || (redirect && !rst);
  end

  assign imem_addr = pc[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      f1_valid <= 1'b0;
      f1_pc    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      count    <= '0;
      f1_valid <= 1'b0;
      f1_pc    <= pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      f1_valid <= issue;
      f1_pc    <= pc;
      wr_ptr   <= wr_ptr + PW'(push);
      rd_ptr   <= rd_ptr + PW'(pop);
      count    <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push && !redirect) begin
      inst_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]   <= f1_pc;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed and random stimulus against a stream-level model of the fetch queue.
// Revision: 1.0
`default_nettype none

module tb_ifetch_queue;

  localparam int IMEM_AW = 15;
  localparam int D       = 2;
`ifdef IFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [26:0]        pc;
  logic               redirect = 1'b0;
  logic [26:0]        npc = '0;
  logic               pc_adv;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata = '0;
  logic               id_valid;
  logic [31:0]        id_inst;
  logic [26:0]        id_pc;
  logic               id_ready = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Model state: words issued but not yet delivered, whether one was issued last cycle,
  // and the PC the next delivered instruction must carry.
  int          outstanding = 0;
  bit          last_issue  = 1'b0;
  logic [26:0] exp_pc      = '0;
  bit          armed       = 1'b0;

  ifetch_queue #(.IMEM_AW(IMEM_AW), .FIFO_DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .redirect   (redirect),
    .pc_adv     (pc_adv),
    .imem_en    (imem_en),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_ready   (id_ready)
  );

  always #5 clk = ~clk;

  // BRAM holds 0x1000 + word address, one-cycle read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= 32'h1000 + {17'b0, imem_addr};
  end

  // PC register: advances by 4 or loads the redirect target when allowed.
  always @(posedge clk) begin
    if (rst)         pc <= '0;
    else if (pc_adv) pc <= redirect ? npc : pc + 27'd4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rd, input logic [26:0] target, input logic rdy);
    int  queued;
    bit  exp_valid;
    bit  exp_deq;
    bit  exp_adv;
    rst      = r;
    redirect = rd;
    npc      = target;
    id_ready = rdy;
    #1;
    if (armed) begin
      queued    = outstanding - (last_issue ? 1 : 0);
      exp_valid = BYP ? (outstanding != 0) : (queued != 0);
      exp_deq   = exp_valid && rdy;
      exp_adv   = !r && (rd || outstanding < D || (outstanding == D && exp_deq));
      check("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
      check("pc_adv", {31'b0, pc_adv}, {31'b0, exp_adv});
      check("imem_en", {31'b0, imem_en}, {31'b0, exp_adv && !rd});
      if (imem_en) check("imem_addr", {17'b0, imem_addr}, {17'b0, pc[16:2]});
      if (exp_deq && !rd && !r) begin
        check("id_pc", {5'b0, id_pc}, {5'b0, exp_pc});
        check("id_inst", id_inst, 32'h1000 + {17'b0, exp_pc[16:2]});
        exp_pc = exp_pc + 27'd4;
      end
      if (r) begin
        outstanding = 0;
        last_issue  = 1'b0;
        exp_pc      = '0;
      end else if (rd) begin
        outstanding = 0;
        last_issue  = 1'b0;
        exp_pc      = target;
      end else begin
        outstanding = outstanding + (imem_en ? 1 : 0) - (exp_deq ? 1 : 0);
        last_issue  = imem_en;
      end
      check("occupancy_bound", {31'b0, outstanding <= D}, 32'd1);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b1);
    armed = 1'b1;
    step(1'b1, 1'b0, '0, 1'b1);

    // Free run: one instruction per cycle, PC 0,4,8,...
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Decode back-pressure, then release.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Redirect to 0x40 with the queue full; first delivered word must be 0x1010.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 27'h40, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Ready toggling 1-0-1-0.
    for (int i = 0; i < 50; i++) step(1'b0, 1'b0, '0, (i % 2) == 0);

    // Reset while stalled and full; fetch restarts at 0.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Reset and redirect together: reset wins.
    step(1'b1, 1'b1, 27'h80, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Random ready, redirects (including misaligned targets) and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 200) == 0, ($urandom % 20) == 0, 27'($urandom), ($urandom % 4) != 0);
    end

    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction-fetch stage directly downstream of the program counter. Each cycle it decides whether the PC may advance, issues a synchronous-read request for the current PC to the instruction BRAM, and captures the returned word with its PC in a small FIFO. The FIFO decouples decode back-pressure from the one-cycle BRAM latency. A redirect from the branch unit kills all in-flight and buffered fetches.

## Interface
Parameters:
- IMEM_AW, 15, instruction-memory word-address width; `imem_addr = pc[IMEM_AW+1:2]`
- FIFO_DEPTH, 2, fetch-queue entries; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- pc  in  27  current PC from the PC register
- redirect  in  1  taken branch/jump this cycle; the PC loads npc when `pc_adv` is high
- pc_adv  out  1  PC may update this cycle; drives the PC's `n_stall`
- imem_en  out  1  BRAM read enable
- imem_addr  out  IMEM_AW  BRAM word address
- imem_rdata  in  32  BRAM data, valid the cycle after `imem_en`
- id_valid  out  1  instruction available to decode
- id_inst  out  32  instruction word
- id_pc  out  27  PC of `id_inst`
- id_ready  in  1  decode accepts this cycle

## Operation
- State:
  - `f1_valid` and `f1_pc` track the single in-flight BRAM request.
  - A FIFO of {inst, pc} entries with `count`.
- Dequeue: `deq = id_valid & id_ready`.
- Issue condition:
  - `issue = !rst & !redirect & ((count + f1_valid < FIFO_DEPTH) | ((count + f1_valid == FIFO_DEPTH) & deq))`.
  - Outputs: `imem_en = issue`, `imem_addr = pc[IMEM_AW+1:2]`, `pc_adv = issue | (redirect & !rst)`.
- Response: at each clock edge with `f1_valid` set, {`imem_rdata`, `f1_pc`} is pushed into the FIFO, unless it is consumed by the bypass (see Configuration).
- Next in-flight state: `f1_valid <= issue`, `f1_pc <= pc`.
- FIFO order is strict; `id_inst`/`id_pc` come from the head entry and `id_valid = (count != 0)`.
- Push and pop in the same cycle are allowed at any occupancy, including full; count is unchanged.
- The credit rule above guarantees the FIFO never overflows. A push into a full FIFO without a pop is a design error; the bench asserts on it.
- Redirect handling:
  - At the edge, `count <= 0`, `f1_valid <= 0`, and the returning BRAM word is discarded.
  - `id_valid` may be high during the redirect cycle. Decode must ignore it; the branch unit owns the kill.
  - Fetch resumes at the target the next cycle.
- `pc[1:0]` is ignored; no misalignment trap.
- `count` wraps modulo FIFO_DEPTH+1 only via legal push/pop; the pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `count = 0`, `f1_valid = 0`, `f1_pc = 0`, FIFO pointers 0. Outputs `id_valid = 0`, `pc_adv = 0`, `imem_en = 0`, `id_inst` and `id_pc` undefined-but-stable (0 recommended).
- First issue happens on the first cycle after `rst` deasserts, with `pc = 0`.
- Latency without bypass: issue at T, data at T+1, `id_valid` at T+2.
- Steady-state throughput is one instruction per cycle while `id_ready` is held high.
- Redirect at cycle R:
  - `pc_adv = 1`, `imem_en = 0`.
  - Target issued at R+1.
  - First target instruction at `id_valid` at R+3 (R+2 with bypass).
- Reset mid-operation flushes everything at the edge; no partial state survives.
- `rst` and `redirect` together: `rst` wins, and `pc_adv = 0`.

## Configuration
- IFETCH_BYPASS_EN defined:
  - When `count == 0` and `f1_valid == 1`, `id_valid = 1` and `id_inst`/`id_pc` are driven combinationally from {`imem_rdata`, `f1_pc`}.
  - If `id_ready` is also high, the word is not pushed.
  - Fetch-to-decode latency drops to 1 cycle, at the cost of the BRAM output sitting on the decode input path.
- Undefined: all data passes through the FIFO registers, giving a 2-cycle latency with a registered decode path.

## Test plan
- Reset then run, `id_ready = 1`, BRAM[i] = 0x1000+i → `id_pc` = 0,4,8,… on consecutive cycles starting cycle 2 (cycle 1 with bypass); `pc_adv` continuously high.
- Hold `id_ready = 0` from cycle 3 → `pc_adv` drops once count+in-flight reach 2; PC frozen. Release → words resume in order with none lost or duplicated.
- Redirect at cycle 6 with 2 entries queued → queue empty at cycle 7. The first delivered `id_pc` equals the npc target (e.g. 0x40) with word 0x1010; nothing from the old stream follows.
- Toggle `id_ready` in a 1-0-1-0 pattern for 50 cycles → delivered sequence equals the PC sequence, with no full-FIFO push assertion.
- Assert `rst` for 1 cycle while the queue is full and a request is in flight → next cycle `id_valid = 0`, `f1_valid = 0`, and fetch restarts at `pc = 0`.
- `rst` and `redirect` high together → `pc_adv = 0` and `imem_en = 0` that cycle.
